instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the ALU instruction decoder: packs decoded-field tuples into 16-bit ALU instruction words and writes them to instruction memory.
//  Used by the loader/self-test path to build programs in IMEM. Illegal field combinations are dropped and flagged.
// PARAMETERS
//  DEPTH     4     output FIFO entries (power of 2, >=2)
//  ADDR_W    8     IMEM address width
//  BASE_ADDR 0     first IMEM address written after start
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       async active-low reset
//  start     in   1       pulse: begin program, load addr=BASE_ADDR
//  in_valid  in   1       field tuple valid
//  in_ready  out  1       tuple accepted when in_valid&in_ready
//  in_last   in   1       tuple is last of program
//  unary     in   1       MOV-form select (only legal with ALU_ADD)
//  imm       in   1       immediate form
//  aluop     in   4       ALU op code (ALU_* in isa_pkg)
//  setcc     in   1       -> instr[10]
//  rd,ra,rb  in   3 each  -> instr[9:7], [6:4], [3:1]
//  immv      in   4       -> instr[3:0] when imm=1
//  mem_we    out  1       IMEM write request
//  mem_ready in   1       IMEM accepts write when mem_we&mem_ready
//  mem_addr  out  ADDR_W  write address
//  mem_wdata out  16      instruction word
//  err       out  1       1-cycle pulse: illegal tuple dropped
//  done      out  1       1-cycle pulse: program fully written
//  err_cnt   out  8       illegal-tuple count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO/stage empty, mem_addr=BASE_ADDR; in_ready, mem_we, err, done = 0; err_cnt=0.
//  FSM IDLE -start-> RUN; RUN -accepted in_last-> DRAIN; DRAIN -stage&FIFO empty-> IDLE, done=1 that cycle. start outside IDLE ignored.
//  in_ready=1 only in RUN when encode stage empty or stage moves into FIFO this cycle (FIFO not full).
//  Encode: word={op5,setcc,rd,ra,(imm? immv : {rb,1'b0}))}. op5[0]=imm.
//  op5 map: ADD u0 0000x, ADD u1 0001x, SUB 0010x, SHL 0011x, SHAR 0100x, SHLR 0101x,
//    RL 0110x, RR 0111x, AND 1000x, OR 1001x, NOT 10110, MULT 1100x.
//  Illegal: XOR, any undefined aluop, unary with aluop!=ADD, NOT with imm=1.
//    Illegal tuple: accepted, registered, then discarded at stage; err pulses the cycle it is discarded; no FIFO write or address advance.
//    Illegal in_last still ends program (DRAIN).
//  Latency: tuple accepted at cycle N -> stage at N+1 -> FIFO at N+1 edge -> mem_we earliest N+2.
//  mem_we = FIFO non-empty; mem_wdata/mem_addr stable while mem_we&!mem_ready.
//  Address: +1 per completed write; wraps 2^ADDR_W-1 -> 0 silently.
//  Sustains 1 word/cycle with mem_ready=1; full FIFO backpressures via in_ready.
//  rst_n low mid-program: everything aborts to reset values; queued words lost, no done.
// CONFIGURATION
//  INSTR_ENC_ERRCNT_EN defined: err_cnt increments per err pulse, saturates at 255, clears on start.
//  Undefined: no counter logic, err_cnt tied 0; err pulse unaffected.
// STRUCTURE
//  isa_pkg: OP_* 5-bit opcodes, ALU_* 4-bit codes, shared with the decoder.
//  Sub-module instr_fifo: sync FIFO, 16+ADDR_W-bit wide, DEPTH deep, full/empty flags.
//  Top holds FSM, encode/legality stage, address counter, error counter.
// TESTING
//  start; ADD rd=1 ra=2 rb=3 setcc=1, last -> write 0x04A6 @0, done one cycle after write completes.
//  ADD imm unary=1 rd=7 immv=0xF; NOT rd=2 ra=5 -> 0x1B8F @0, 0xB150 @1.
//  XOR tuple; NOT imm=1 -> both dropped, err pulses x2, no mem_we, err_cnt=2 (macro on) / 0 (off).
//  mem_ready=0 for 10 cycles, 6 tuples offered -> in_ready drops after DEPTH+1 accepted, order/addr preserved.
//  BASE_ADDR=254, 4 words -> addresses 254,255,0,1.
//  rst_n low with 3 words queued -> mem_we=0, in_ready=0, addr=BASE_ADDR immediately; no done.

Source files
------------

// File: rtl/isa_pkg.sv
// ALU instruction-set definitions shared by the instruction decoder and encoder.
package isa_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SHL  = 4'd2,
      ALU_SHAR = 4'd3,
      ALU_SHLR = 4'd4,
      ALU_RL   = 4'd5,
      ALU_RR   = 4'd6,
      ALU_AND  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_XOR  = 4'd9,
      ALU_NOT  = 4'd10,
      ALU_MULT = 4'd11
   } alu_op_e;

   // Bit 0 of every opcode is the immediate-form flag, so it is left clear here.
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_MOV  = 5'b00010;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_SHAR = 5'b01000;
   localparam logic [4:0] OP_SHLR = 5'b01010;
   localparam logic [4:0] OP_RL   = 5'b01100;
   localparam logic [4:0] OP_RR   = 5'b01110;
   localparam logic [4:0] OP_AND  = 5'b10000;
   localparam logic [4:0] OP_OR   = 5'b10010;
   localparam logic [4:0] OP_NOT  = 5'b10110;
   localparam logic [4:0] OP_MULT = 5'b11000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } enc_state_e;

   typedef struct packed {
      logic       legal;
      logic [4:0] op5;
   } op_sel_t;

   function automatic op_sel_t op_lookup(logic [3:0] aluop, logic unary, logic imm);
      op_sel_t r;
      r.legal = !unary;
      r.op5   = OP_ADD;
      case (aluop)
         ALU_ADD:  begin r.legal = 1'b1; r.op5 = unary ? OP_MOV : OP_ADD; end
         ALU_SUB:  r.op5 = OP_SUB;
         ALU_SHL:  r.op5 = OP_SHL;
         ALU_SHAR: r.op5 = OP_SHAR;
         ALU_SHLR: r.op5 = OP_SHLR;
         ALU_RL:   r.op5 = OP_RL;
         ALU_RR:   r.op5 = OP_RR;
         ALU_AND:  r.op5 = OP_AND;
         ALU_OR:   r.op5 = OP_OR;
         ALU_NOT:  begin r.op5 = OP_NOT; r.legal = !unary && !imm; end
         ALU_MULT: r.op5 = OP_MULT;
         default:  r.legal = 1'b0;
      endcase
      r.op5 = r.op5 | {4'b0000, imm};
      return r;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {address, instruction word} entries awaiting IMEM write.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded ALU field tuples into 16-bit instruction words and streams them into IMEM.
// Optional illegal-tuple counter enabled by defining INSTR_ENC_ERRCNT_EN.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic              unary,
   input  logic              imm,
   input  logic [3:0]        aluop,
   input  logic              setcc,
   input  logic [2:0]        rd,
   input  logic [2:0]        ra,
   input  logic [2:0]        rb,
   input  logic [3:0]        immv,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              err,
   output logic              done,
   output logic [7:0]        err_cnt
);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam int FW = 16 + ADDR_W;

   enc_state_e        state_q, state_d;
   logic              stg_vld_q, stg_vld_d, stg_legal_q, stg_legal_d;
   logic [15:0]       stg_word_q, stg_word_d;
   logic [ADDR_W-1:0] push_addr_q, push_addr_d;
   op_sel_t           sel;
   logic              start_go, stg_free, accept, push, pop;
   logic              fifo_full, fifo_empty;
   logic [FW-1:0]     fifo_rdata;

   // The stage frees up when empty, when its word drains into the FIFO, or when it is dropped.
   assign stg_free  = !stg_vld_q || !stg_legal_q || !fifo_full;
   assign in_ready  = (state_q == S_RUN) && stg_free;
   assign accept    = in_valid && in_ready;
   assign push      = stg_vld_q && stg_legal_q && !fifo_full;
   assign pop       = !fifo_empty && mem_ready;
   assign start_go  = (state_q == S_IDLE) && start;
   assign err       = stg_vld_q && !stg_legal_q;
   assign done      = (state_q == S_DRAIN) && !stg_vld_q && fifo_empty;
   assign mem_we    = !fifo_empty;
   assign mem_wdata = fifo_rdata[15:0];
   assign mem_addr  = fifo_empty ? push_addr_q : fifo_rdata[16 +: ADDR_W];

   always_comb begin
      sel         = op_lookup(aluop, unary, imm);
      state_d     = state_q;
      stg_vld_d   = stg_vld_q;
      stg_legal_d = stg_legal_q;
      stg_word_d  = stg_word_q;
      push_addr_d = push_addr_q;
      case (state_q)
         S_IDLE:  if (start_go) begin state_d = S_RUN; push_addr_d = BASE_A; end
         S_RUN:   if (accept && in_last) state_d = S_DRAIN;
         S_DRAIN: if (done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (push) push_addr_d = push_addr_q + ADDR_W'(1);
      if (stg_free) stg_vld_d = 1'b0;
      if (accept) begin
         stg_vld_d   = 1'b1;
         stg_legal_d = sel.legal;
         stg_word_d  = {sel.op5, setcc, rd, ra, (imm ? immv : {rb, 1'b0})};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         stg_vld_q   <= 1'b0;
         stg_legal_q <= 1'b0;
         push_addr_q <= BASE_A;
      end else begin
         state_q     <= state_d;
         stg_vld_q   <= stg_vld_d;
         stg_legal_q <= stg_legal_d;
         push_addr_q <= push_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      stg_word_q <= stg_word_d;
   end

`ifdef INSTR_ENC_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (start_go) err_cnt_d = '0;
      else if (err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

   instr_fifo #(
      .DEPTH (DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({push_addr_q, stg_word_q}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: two instances (base 0 and base 254) share all stimulus.
module tb_instr_encoder;
   import isa_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
   localparam int BASE1  = 254;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0, unary = 1'b0, imm = 1'b0;
   logic setcc = 1'b0, mem_ready = 1'b0;
   logic [3:0] aluop = '0, immv = '0;
   logic [2:0] rd = '0, ra = '0, rb = '0;

   logic in_ready0, mem_we0, err0, done0, in_ready1, mem_we1, err1, done1;
   logic [ADDR_W-1:0] mem_addr0, mem_addr1;
   logic [15:0] mem_wdata0, mem_wdata1;
   logic [7:0] err_cnt0, err_cnt1;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
      .in_last(in_last), .unary(unary), .imm(imm), .aluop(aluop), .setcc(setcc),
      .rd(rd), .ra(ra), .rb(rb), .immv(immv), .mem_we(mem_we0), .mem_ready(mem_ready),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .err(err0), .done(done0), .err_cnt(err_cnt0));

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
      .in_last(in_last), .unary(unary), .imm(imm), .aluop(aluop), .setcc(setcc),
      .rd(rd), .ra(ra), .rb(rb), .immv(immv), .mem_we(mem_we1), .mem_ready(mem_ready),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .err(err1), .done(done1), .err_cnt(err_cnt1));

   typedef struct {
      logic [15:0] word;
      logic [7:0]  addr;
   } exp_t;

   exp_t q0[$], q1[$];
   exp_t e0, e1;
   logic [15:0] log0[$];
   logic [7:0]  alog0[$], alog1[$];

   int n_chk = 0, n_pass = 0;
   int prog_idx = 0, err_exp = 0, acc_cnt = 0;
   int err_seen0 = 0, err_seen1 = 0, done_seen0 = 0, done_seen1 = 0;
   int err_base0 = 0, err_base1 = 0, done_base0 = 0, done_base1 = 0, log_base = 0;
   int rdy_mode = 1;
   bit hold0 = 1'b0, hold1 = 1'b0;
   logic [15:0] hw0, hw1;
   logic [7:0]  ha0, ha1;

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
   endtask

   // Reference encoding: opcode group index * 2 + imm, then fields placed by weight.
   function automatic logic [16:0] ref_encode(logic [3:0] a, logic un, logic im, logic sc,
                                              logic [2:0] d, logic [2:0] s1, logic [2:0] s2,
                                              logic [3:0] iv);
      int grp;
      int w;
      grp = -1;
      if (a == ALU_ADD) grp = un ? 1 : 0;
      else if (!un) begin
         case (a)
            ALU_SUB:  grp = 2;
            ALU_SHL:  grp = 3;
            ALU_SHAR: grp = 4;
            ALU_SHLR: grp = 5;
            ALU_RL:   grp = 6;
            ALU_RR:   grp = 7;
            ALU_AND:  grp = 8;
            ALU_OR:   grp = 9;
            ALU_NOT:  grp = im ? -1 : 11;
            ALU_MULT: grp = 12;
            default:  grp = -1;
         endcase
      end
      if (grp < 0) return 17'h0;
      w = (grp * 2 + int'(im)) * 2048 + int'(sc) * 1024 + int'(d) * 128 + int'(s1) * 16
          + (im ? int'(iv) : int'(s2) * 2);
      return {1'b1, w[15:0]};
   endfunction

   task automatic model_accept();
      logic [16:0] r;
      r = ref_encode(aluop, unary, imm, setcc, rd, ra, rb, immv);
      acc_cnt++;
      if (r[16]) begin
         q0.push_back('{word: r[15:0], addr: 8'(prog_idx)});
         q1.push_back('{word: r[15:0], addr: 8'(BASE1 + prog_idx)});
         prog_idx++;
      end else begin
         err_exp++;
      end
   endtask

   // Monitor: pops the scoreboard on every completed IMEM write.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold0 = 1'b0;
         hold1 = 1'b0;
      end else begin
         if (hold0) begin
            check("hold_we0", int'(mem_we0), 1);
            check("hold_word0", int'(mem_wdata0), int'(hw0));
            check("hold_addr0", int'(mem_addr0), int'(ha0));
         end
         if (hold1) begin
            check("hold_word1", int'(mem_wdata1), int'(hw1));
            check("hold_addr1", int'(mem_addr1), int'(ha1));
         end
         hold0 = mem_we0 && !mem_ready;
         hold1 = mem_we1 && !mem_ready;
         hw0 = mem_wdata0; ha0 = mem_addr0;
         hw1 = mem_wdata1; ha1 = mem_addr1;
         if (mem_we0 && mem_ready) begin
            if (q0.size() == 0) check("unexpected_write0", int'(mem_wdata0), -1);
            else begin
               e0 = q0.pop_front();
               check("wdata0", int'(mem_wdata0), int'(e0.word));
               check("waddr0", int'(mem_addr0), int'(e0.addr));
               log0.push_back(mem_wdata0);
               alog0.push_back(mem_addr0);
            end
         end
         if (mem_we1 && mem_ready) begin
            if (q1.size() == 0) check("unexpected_write1", int'(mem_wdata1), -1);
            else begin
               e1 = q1.pop_front();
               check("wdata1", int'(mem_wdata1), int'(e1.word));
               check("waddr1", int'(mem_addr1), int'(e1.addr));
               alog1.push_back(mem_addr1);
            end
         end
         if (err0) err_seen0++;
         if (err1) err_seen1++;
         if (done0) begin
            done_seen0++;
            check("done_after_writes0", q0.size(), 0);
         end
         if (done1) begin
            done_seen1++;
            check("done_after_writes1", q1.size(), 0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1)      mem_ready = 1'b1;
         else if (rdy_mode == 2) mem_ready = 1'b0;
         else                    mem_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_prog();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      prog_idx  = 0;
      err_exp   = 0;
      acc_cnt   = 0;
      err_base0 = err_seen0;
      err_base1 = err_seen1;
      done_base0 = done_seen0;
      done_base1 = done_seen1;
      log_base  = log0.size();
   endtask

   task automatic send(logic [3:0] op, logic un, logic im, logic sc, logic [2:0] d,
                       logic [2:0] s1, logic [2:0] s2, logic [3:0] iv, logic last);
      bit ok;
      aluop = op; unary = un; imm = im; setcc = sc;
      rd = d; ra = s1; rb = s2; immv = iv; in_last = last;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (in_ready0) begin
            model_accept();
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic send_rand(logic last);
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), last);
   endtask

   task automatic send_legal(logic last);
      send(4'($urandom_range(0, 8)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), last);
   endtask

   task automatic end_prog();
      int c;
      int exp_cnt;
      c = 0;
      while (done_seen0 == done_base0 && c < 500) begin
         tick(1);
         c++;
      end
      tick(2);
      check("done_once0", done_seen0 - done_base0, 1);
      check("done_once1", done_seen1 - done_base1, 1);
      check("err_pulses0", err_seen0 - err_base0, err_exp);
      check("err_pulses1", err_seen1 - err_base1, err_exp);
`ifdef INSTR_ENC_ERRCNT_EN
      exp_cnt = (err_exp > 255) ? 255 : err_exp;
`else
      exp_cnt = 0;
`endif
      check("err_cnt0", int'(err_cnt0), exp_cnt);
      check("err_cnt1", int'(err_cnt1), exp_cnt);
      check("queue_empty0", q0.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", int'(in_ready0), 0);
      check("rst_mem_we", int'(mem_we0), 0);
      check("rst_err", int'(err0), 0);
      check("rst_done", int'(done0), 0);
      check("rst_err_cnt", int'(err_cnt0), 0);
      check("rst_addr0", int'(mem_addr0), 0);
      check("rst_addr1", int'(mem_addr1), BASE1);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("idle_in_ready", int'(in_ready0), 0);

      // Single ADD with setcc
      rdy_mode = 1;
      tick(1);
      start_prog();
      send(ALU_ADD, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 4'd0, 1'b1);
      end_prog();
      check("t1_word", int'(log0[log_base]), 16'h04A6);
      check("t1_addr0", int'(alog0[log_base]), 0);
      check("t1_addr1", int'(alog1[log_base]), BASE1);

      // MOV immediate followed by NOT
      start_prog();
      send(ALU_ADD, 1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 4'hF, 1'b0);
      send(ALU_NOT, 1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 3'd0, 4'h0, 1'b1);
      end_prog();
      check("t2_count", log0.size() - log_base, 2);
      check("t2_word0", int'(log0[log_base]), 16'h1B8F);
      check("t2_word1", int'(log0[log_base + 1]), 16'hB150);
      check("t2_addr0", int'(alog0[log_base + 1]), 1);
      check("t2_addr1", int'(alog1[log_base + 1]), 255);

      // Two illegal tuples, the second one last
      start_prog();
      send(ALU_XOR, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 3'd1, 4'd0, 1'b0);
      send(ALU_NOT, 1'b0, 1'b1, 1'b0, 3'd3, 3'd4, 3'd0, 4'd9, 1'b1);
      end_prog();
      check("t3_err", err_seen0 - err_base0, 2);
      check("t3_nowrite", log0.size() - log_base, 0);

      // Backpressure with IMEM stalled
      rdy_mode = 2;
      tick(1);
      start_prog();
      fork
         begin
            for (int i = 0; i < 6; i++) send_legal(i == 5);
         end
         begin
            tick(10);
            check("bp_accepted", acc_cnt, DEPTH + 1);
            check("bp_in_ready", int'(in_ready0), 0);
            rdy_mode = 1;
         end
      join
      end_prog();
      check("bp_words", log0.size() - log_base, 6);
      for (int i = 0; i < 6; i++) check("bp_order_addr", int'(alog1[log_base + i]), (BASE1 + i) % 256);

      // Random programs with random IMEM stalls
      rdy_mode = 0;
      for (int p = 0; p < 6; p++) begin
         start_prog();
         n = $urandom_range(2, 10);
         for (int i = 0; i < n; i++) begin
            send_rand(i == n - 1);
            if (p == 2 && i == 0 && n > 1) begin
               start = 1'b1;
               tick(1);
               start = 1'b0;
            end
            tick($urandom_range(0, 2));
         end
         end_prog();
      end

      // Reset with words queued
      rdy_mode = 2;
      tick(1);
      start_prog();
      for (int i = 0; i < 3; i++) send_legal(1'b0);
      tick(3);
      check("pre_rst_we", int'(mem_we0), 1);
      done_base0 = done_seen0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_mem_we", int'(mem_we0), 0);
      check("arst_in_ready", int'(in_ready0), 0);
      check("arst_addr0", int'(mem_addr0), 0);
      check("arst_addr1", int'(mem_addr1), BASE1);
      q0.delete();
      q1.delete();
      tick(3);
      rst_n = 1'b1;
      rdy_mode = 1;
      tick(5);
      check("post_rst_we", int'(mem_we0), 0);
      check("post_rst_no_done", done_seen0 - done_base0, 0);

      // Recovery program after reset
      start_prog();
      send_legal(1'b0);
      send_legal(1'b1);
      end_prog();
      check("rec_addr0", int'(alog0[alog0.size() - 1]), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
